// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared types and helpers for the sequential binary-to-BCD
//               converter: FSM state encoding, nibble width, and the largest
//               decimal value a given number of BCD digits can hold.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    // Width of one packed BCD digit.
    localparam int c_NIB_W = 4;

    // Converter FSM states, explicit 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Largest value representable with 'digits' decimal digits (10**digits - 1).
    function automatic int max_dec(input int digits);
        int r;
        r = 1;
        for (int i = 0; i < digits; i++) begin
            r = r * 10;
        end
        return r - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
// Module      : bcd_add3
// Description : Combinational double-dabble nibble corrector. A digit of 5 or
//               more gets +3 so the following left shift carries into the next
//               decimal digit.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [c_NIB_W-1:0] i_nib,
    output logic [c_NIB_W-1:0] o_nib
);

    assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_seq
// Description : Sequential binary-to-BCD converter, one input bit per clock
//               (shift-add-3). Accepts bin_in on a start pulse while idle and
//               delivers DIGITS packed BCD nibbles with a one-cycle done pulse.
//               Inputs above 10**DIGITS-1 saturate to all nines with ovf set.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin_in,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf,
    output logic [c_NIB_W*DIGITS-1:0] bcd_out
);

    localparam int c_SCR_W = c_NIB_W * DIGITS;
    localparam int c_CNT_W = $clog2(BIN_W + 1);
    localparam int c_MAX   = max_dec(DIGITS);
    localparam logic [c_SCR_W-1:0] c_SAT = {DIGITS{4'h9}};

    state_t               r_state,   w_state_nx;
    logic [BIN_W-1:0]     r_shreg,   w_shreg_nx;
    logic [c_SCR_W-1:0]   r_scratch, w_scratch_nx;
    logic [c_CNT_W-1:0]   r_cnt,     w_cnt_nx;
    logic                 r_ovf_next, w_ovf_next_nx;
    logic [c_SCR_W-1:0]   r_bcd,     w_bcd_nx;
    logic                 r_ovf,     w_ovf_nx;
    logic                 r_done,    w_done_nx;

    // Scratch digits after the add-3 correction, ready to be shifted.
    logic [c_SCR_W-1:0]   w_adj;

    // One corrector per BCD digit of the scratch register.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_nib (r_scratch[g*c_NIB_W +: c_NIB_W]),
            .o_nib (w_adj[g*c_NIB_W +: c_NIB_W])
        );
    end

    // Next-state and datapath update; everything holds unless the state acts.
    always_comb begin
        w_state_nx    = r_state;
        w_shreg_nx    = r_shreg;
        w_scratch_nx  = r_scratch;
        w_cnt_nx      = r_cnt;
        w_ovf_next_nx = r_ovf_next;
        w_bcd_nx      = r_bcd;
        w_ovf_nx      = r_ovf;
        w_done_nx     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_shreg_nx    = bin_in;
                    w_scratch_nx  = '0;
                    w_cnt_nx      = '0;
                    w_ovf_next_nx = (32'(bin_in) > 32'(c_MAX));
                    w_state_nx    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Correct first, then shift the MSB of the binary into the digits.
                {w_scratch_nx, w_shreg_nx} = {w_adj[c_SCR_W-2:0], r_shreg, 1'b0};
                w_cnt_nx = r_cnt + 1'b1;
                if (r_cnt == c_CNT_W'(BIN_W - 1)) begin
                    w_state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                // Any carry lost from the top digit only happens when saturating.
                w_bcd_nx   = r_ovf_next ? c_SAT : r_scratch;
                w_ovf_nx   = r_ovf_next;
                w_done_nx  = 1'b1;
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // All converter state; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_shreg    <= '0;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_ovf_next <= 1'b0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_shreg    <= w_shreg_nx;
            r_scratch  <= w_scratch_nx;
            r_cnt      <= w_cnt_nx;
            r_ovf_next <= w_ovf_next_nx;
            r_bcd      <= w_bcd_nx;
            r_ovf      <= w_ovf_nx;
            r_done     <= w_done_nx;
        end
    end

    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;
    assign ovf     = r_ovf;
    assign bcd_out = r_bcd;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_to_bcd_seq
// Description : Self-checking bench for bin_to_bcd_seq with directed vectors,
//               busy-start handling, back-to-back, reset abort and a full sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  bin_in = '0;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [11:0] bcd_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(
        .BIN_W  (10),
        .DIGITS (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf),
        .bcd_out (bcd_out)
    );

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits by division, saturating above 999.
    function automatic logic [11:0] ref_bcd(input int v);
        if (v > 999) return 12'h999;
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // One full conversion with latency, busy length, output stability and pulse width checks.
    task automatic run_conv(input int v, input string tag);
        logic [11:0] prev;
        logic        prev_ovf;
        int          lat;
        int          busy_cnt;
        int          n;
        bit          stable;
        bit          seen;
        prev     = bcd_out;
        prev_ovf = ovf;
        @(negedge clk);
        start  = 1'b1;
        bin_in = 10'(v);
        @(posedge clk);
        #1;
        start  = 1'b0;
        bin_in = 10'($urandom);
        lat = 0; busy_cnt = 0; stable = 1'b1; seen = 1'b0; n = 1;
        while (!seen && n <= 20) begin
            if (done) begin
                seen = 1'b1;
                lat  = n;
            end else begin
                if (busy) busy_cnt++;
                if (bcd_out !== prev || ovf !== prev_ovf) stable = 1'b0;
                @(posedge clk);
                #1;
                n++;
            end
        end
        check($sformatf("%s latency", tag), lat, 12);
        check($sformatf("%s busy_cycles", tag), busy_cnt, 11);
        check($sformatf("%s stable", tag), {31'd0, stable}, 1);
        check($sformatf("%s bcd", tag), {20'd0, bcd_out}, {20'd0, ref_bcd(v)});
        check($sformatf("%s ovf", tag), {31'd0, ovf}, {31'd0, (v > 999)});
        @(posedge clk);
        #1;
        check($sformatf("%s done_width", tag), {31'd0, done}, 0);
    endtask

    initial begin
        int done_cnt;
        int t[3];
        int nt;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", {31'd0, busy}, 0);
        check("rst done", {31'd0, done}, 0);
        check("rst ovf", {31'd0, ovf}, 0);
        check("rst bcd", {20'd0, bcd_out}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed values
        run_conv(0,    "v0");
        run_conv(255,  "v255");
        check("v255 digits", {20'd0, bcd_out}, 32'h255);
        run_conv(999,  "v999");
        check("v999 digits", {20'd0, bcd_out}, 32'h999);
        run_conv(10,   "v10");
        check("v10 digits", {20'd0, bcd_out}, 32'h010);
        run_conv(1000, "v1000");
        check("v1000 ovf", {31'd0, ovf}, 1);
        run_conv(1023, "v1023");
        check("v1023 digits", {20'd0, bcd_out}, 32'h999);
        run_conv(7,    "v7");
        check("v7 ovf clr", {31'd0, ovf}, 0);

        // Start pulses during busy are ignored
        @(negedge clk);
        start  = 1'b1;
        bin_in = 10'd123;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_cnt = 0;
        for (int c = 1; c <= 30; c++) begin
            if (done) done_cnt++;
            if (c >= 2 && c <= 9) begin
                start  = c[0];
                bin_in = 10'd456;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        check("busy_start dones", done_cnt, 1);
        check("busy_start bcd", {20'd0, bcd_out}, 32'h123);

        // Start held high: one result every 12 cycles
        @(negedge clk);
        start  = 1'b1;
        bin_in = 10'd5;
        nt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (done && nt < 3) begin
                t[nt] = c;
                nt++;
            end
        end
        start = 1'b0;
        check("b2b count", nt, 3);
        check("b2b gap1", t[1] - t[0], 12);
        check("b2b gap2", t[2] - t[1], 12);
        check("b2b bcd", {20'd0, bcd_out}, 32'h005);
        repeat (15) @(posedge clk);

        // Reset in the middle of a conversion
        @(negedge clk);
        start  = 1'b1;
        bin_in = 10'd321;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 0);
        check("abort bcd", {20'd0, bcd_out}, 0);
        check("abort ovf", {31'd0, ovf}, 0);
        check("abort done", {31'd0, done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check("abort no_done", done_cnt, 0);
        run_conv(321, "v321");
        check("v321 digits", {20'd0, bcd_out}, 32'h321);

        // Full input range against the reference
        for (int v = 0; v < 1024; v++) begin
            run_conv(v, $sformatf("sweep%0d", v));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
